// File: rtl/spi_master_mode.sv
// spi_master_mode
//   Parametrised SPI master for a single external slave. One frame of DW bits
//   is shifted out on spi_mosi while DW bits are shifted in from spi_miso. All
//   four CPOL/CPHA modes are selectable per transfer, and the bit order is
//   fixed by MSB_FIRST.
//
// Parameters
//   DW         frame width in bits (>= 2)
//   CW         width of dvsr and of the half-period counter
//   MSB_FIRST  1: MSB first on the wire, 0: LSB first
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   din            transmit word, taken when wr_sd is seen in IDLE
//   dvsr           SCK half-period in clk cycles (0 behaves as 1)
//   cpol, cpha     SPI mode for the transfer, taken together with din
//   wr_sd          start-transfer strobe (ignored unless idle)
//   dout           received word
//   spi_clk        SCK, registered
//   spi_mosi       serial data out
//   spi_miso       serial data in
//   spi_ss_n       slave select, active low, registered
//   spi_done_tick  one-cycle pulse in the last cycle of a frame
//   spi_idle       high when a new wr_sd will be accepted
module spi_master_mode #(
  parameter int DW        = 8,
  parameter int CW        = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] dvsr,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          wr_sd,
  output logic [DW-1:0] dout,
  output logic          spi_clk,
  output logic          spi_mosi,
  input  logic          spi_miso,
  output logic          spi_ss_n,
  output logic          spi_done_tick,
  output logic          spi_idle
);

  localparam int BW = $clog2(DW);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CPHA_DLY = 2'd1;
  localparam logic [1:0] P0       = 2'd2;
  localparam logic [1:0] P1       = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] c_reg, c_next;
  logic [CW-1:0] h_reg, h_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [DW-1:0] sout_reg, sout_next;
  logic [DW-1:0] sin_reg, sin_next;
  logic          cpol_reg, cpol_next;
  logic          cpha_reg, cpha_next;
  logic          sck_reg, sck_next;
  logic          ss_n_reg, ss_n_next;
  logic          h_end;

  // Every non-idle state lasts exactly one half-period of the latched divider.
  assign h_end = (c_reg == (h_reg - CW'(1)));

  // State, datapath and output registers; reset forces slave select high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      h_reg     <= '0;
      bit_reg   <= '0;
      sout_reg  <= '0;
      sin_reg   <= '0;
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
      sck_reg   <= 1'b0;
      ss_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      h_reg     <= h_next;
      bit_reg   <= bit_next;
      sout_reg  <= sout_next;
      sin_reg   <= sin_next;
      cpol_reg  <= cpol_next;
      cpha_reg  <= cpha_next;
      sck_reg   <= sck_next;
      ss_n_reg  <= ss_n_next;
    end
  end

  // Next-state logic. Divider and mode are captured only at the start of a
  // frame so that the bus inputs may change freely while a frame is running.
  always_comb begin
    state_next    = state_reg;
    c_next        = c_reg;
    h_next        = h_reg;
    bit_next      = bit_reg;
    sout_next     = sout_reg;
    sin_next      = sin_reg;
    cpol_next     = cpol_reg;
    cpha_next     = cpha_reg;
    spi_done_tick = 1'b0;
    spi_idle      = 1'b0;

    case (state_reg)
      IDLE: begin
        spi_idle = 1'b1;
        if (wr_sd) begin
          sout_next  = din;
          bit_next   = '0;
          c_next     = '0;
          h_next     = (dvsr == '0) ? CW'(1) : dvsr;
          cpol_next  = cpol;
          cpha_next  = cpha;
          state_next = cpha ? CPHA_DLY : P0;
        end
      end

      CPHA_DLY: begin
        if (h_end) begin
          c_next     = '0;
          state_next = P0;
        end else begin
          c_next = c_reg + CW'(1);
        end
      end

      P0: begin
        if (h_end) begin
          c_next     = '0;
          state_next = P1;
          if (MSB_FIRST != 0) begin
            sin_next = {sin_reg[DW-2:0], spi_miso};
          end else begin
            sin_next = {spi_miso, sin_reg[DW-1:1]};
          end
        end else begin
          c_next = c_reg + CW'(1);
        end
      end

      P1: begin
        if (h_end) begin
          c_next = '0;
          if (bit_reg == LAST_BIT) begin
            spi_done_tick = 1'b1;
            state_next    = IDLE;
          end else begin
            bit_next   = bit_reg + BW'(1);
            state_next = P0;
            if (MSB_FIRST != 0) begin
              sout_next = {sout_reg[DW-2:0], 1'b0};
            end else begin
              sout_next = {1'b0, sout_reg[DW-1:1]};
            end
          end
        end else begin
          c_next = c_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // SCK and slave select are computed from the upcoming state and then
    // registered, so both pins change cleanly on a clk edge.
    sck_next  = (cpha_next ? (state_next == P0) : (state_next == P1)) ^ cpol_next;
    ss_n_next = (state_next == IDLE);
  end

  assign spi_clk  = sck_reg;
  assign spi_ss_n = ss_n_reg;
  assign spi_mosi = (MSB_FIRST != 0) ? sout_reg[DW-1] : sout_reg[0];
  assign dout     = sin_reg;

endmodule
